// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - raw button in, conditioned level and event pulses out
interface btn_conditioner_if;
  logic i_btn;
  logic o_level;
  logic o_press;
  logic o_release;
  logic o_short;
  logic o_long;
  logic o_repeat;

  modport master (
    output i_btn,
    input  o_level,
    input  o_press,
    input  o_release,
    input  o_short,
    input  o_long,
    input  o_repeat
  );

  modport slave (
    input  i_btn,
    output o_level,
    output o_press,
    output o_release,
    output o_short,
    output o_long,
    output o_repeat
  );
endinterface

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - sync, debounce, press/release edges, short/long/repeat classification
module btn_conditioner #(
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CYC = 270000,
  parameter int LONG_CYC     = 27000000,
  parameter int REPEAT_CYC   = 5400000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  btn_conditioner_if.slave  bus
);

  localparam int DW   = $clog2(DEBOUNCE_CYC) + 1;
  localparam int HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HW   = $clog2(HMAX) + 1;

  localparam logic          RAW_IDLE  = ACTIVE_LOW;
  localparam logic [DW-1:0] DB_TERM   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] LONG_TERM = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] REP_TERM  = HW'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);
  localparam bit            REP_EN    = (REPEAT_CYC > 0);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  logic          sync1_q;
  logic          sync2_q;
  logic          pressed;

  logic [DW-1:0] db_cnt_q;
  logic [DW-1:0] db_cnt_d;
  logic          level_q;
  logic          level_d;
  logic          press_evt;
  logic          release_evt;
  logic          press_q;
  logic          release_q;

  state_t        state_q;
  logic [HW-1:0] hold_cnt_q;
  logic          short_q;
  logic          long_q;
  logic          repeat_q;

  // Reset loads the released pin value so no phantom edge appears on exit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
    end else begin
      sync1_q <= bus.i_btn;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    db_cnt_d    = db_cnt_q;
    level_d     = level_q;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    if (pressed == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_TERM) begin
      db_cnt_d    = '0;
      level_d     = pressed;
      press_evt   = pressed;
      release_evt = !pressed;
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_evt;
      release_q <= release_evt;
    end
  end

  // Release is checked first so it beats a long/repeat terminal count in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press_evt) begin
            state_q    <= PRESSED;
            hold_cnt_q <= '0;
          end
        end
        PRESSED: begin
          if (release_evt) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            short_q    <= 1'b1;
          end else if (hold_cnt_q == LONG_TERM) begin
            state_q    <= HELD;
            hold_cnt_q <= '0;
            long_q     <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        HELD: begin
          if (release_evt) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
          end else if (REP_EN) begin
            if (hold_cnt_q == REP_TERM) begin
              hold_cnt_q <= '0;
              repeat_q   <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_q + HW'(1);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.o_level   = level_q;
  assign bus.o_press   = press_q;
  assign bus.o_release = release_q;
  assign bus.o_short   = short_q;
  assign bus.o_long    = long_q;
  assign bus.o_repeat  = repeat_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed per-scenario bench, outputs packed as {level,press,release,short,long,repeat}
module tb_btn_conditioner;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn   = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  btn_conditioner_if bus ();
  btn_conditioner_if bus0 ();

  assign bus.i_btn  = btn;
  assign bus0.i_btn = btn;

  btn_conditioner #(
    .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(5)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave)
  );

  btn_conditioner #(
    .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(0)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave)
  );

  logic [5:0] got;
  logic [5:0] got0;
  assign got  = {bus.o_level, bus.o_press, bus.o_release, bus.o_short, bus.o_long, bus.o_repeat};
  assign got0 = {bus0.o_level, bus0.o_press, bus0.o_release, bus0.o_short, bus0.o_long, bus0.o_repeat};

  // Reset deasserts 1 time unit after an edge; that edge is t=0.
  task automatic do_reset();
    rst_n = 1'b0;
    btn   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 1'b1;
    #1;
    n_vec++;
    if ({got, got0} !== 12'b0) begin
      n_bad++;
      $display("FAIL reset_in t=0 got=%b/%b exp=000000/000000", got, got0);
    end
    do_reset();
    for (int t = 0; t < 8; t++) begin
      n_vec++;
      if ({got, got0} !== 12'b0) begin
        n_bad++;
        $display("FAIL reset_idle t=%0d got=%b/%b exp=000000/000000", t, got, got0);
      end
      step();
    end
  endtask

  task automatic test_glitch();
    logic [5:0] exp;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      exp = 6'b0;
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL glitch t=%0d got=%b exp=%b", t, got, exp);
      end
      btn = (t >= 10 && t <= 12) ? 1'b0 : 1'b1;
      step();
    end
  endtask

  task automatic test_short();
    logic [5:0] exp;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      exp = {(t >= 16 && t < 31), t == 16, t == 31, t == 31, 1'b0, 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL short_press t=%0d got=%b exp=%b", t, got, exp);
      end
      btn = (t >= 10 && t <= 24) ? 1'b0 : 1'b1;
      step();
    end
  endtask

  task automatic test_long_repeat();
    logic [5:0] exp;
    do_reset();
    for (int t = 0; t < 80; t++) begin
      exp = {(t >= 16 && t < 67), t == 16, t == 67, 1'b0, t == 36,
             (t >= 41 && t <= 66 && (t - 41) % 5 == 0)};
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL long_repeat t=%0d got=%b exp=%b", t, got, exp);
      end
      btn = (t >= 10 && t <= 60) ? 1'b0 : 1'b1;
      step();
    end
  endtask

  task automatic test_bouncy_release();
    logic [5:0] exp;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      exp = {(t >= 16 && t < 30), t == 16, t == 30, t == 30, 1'b0, 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL bouncy_release t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t >= 10 && t <= 19)
        btn = 1'b0;
      else if (t >= 20 && t <= 23)
        btn = (t % 2 == 0) ? 1'b1 : 1'b0;
      else
        btn = 1'b1;
      step();
    end
  endtask

  task automatic test_release_vs_long();
    logic [5:0] exp;
    do_reset();
    for (int t = 0; t < 45; t++) begin
      exp = {(t >= 16 && t < 36), t == 16, t == 36, t == 36, 1'b0, 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL release_vs_long t=%0d got=%b exp=%b", t, got, exp);
      end
      btn = (t >= 10 && t <= 29) ? 1'b0 : 1'b1;
      step();
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] exp;
    do_reset();
    for (int t = 0; t <= 40; t++) begin
      exp = {t >= 16, t == 16, 1'b0, 1'b0, t == 36, 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL pre_reset_hold t=%0d got=%b exp=%b", t, got, exp);
      end
      btn = (t >= 10) ? 1'b0 : 1'b1;
      if (t < 40) step();
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({got, got0} !== 12'b0) begin
      n_bad++;
      $display("FAIL async_reset t=40 got=%b/%b exp=000000/000000", got, got0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 30; t++) begin
      exp = {t >= 6, t == 6, 1'b0, 1'b0, t == 26, 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL post_reset_hold t=%0d got=%b exp=%b", t, got, exp);
      end
      step();
    end
    btn = 1'b1;
  endtask

  task automatic test_no_repeat();
    logic [5:0] exp;
    logic [5:0] exp0;
    do_reset();
    for (int t = 0; t < 80; t++) begin
      exp0 = {(t >= 16 && t < 66), t == 16, t == 66, 1'b0, t == 36, 1'b0};
      exp  = {(t >= 16 && t < 66), t == 16, t == 66, 1'b0, t == 36,
              (t >= 41 && t <= 61 && (t - 41) % 5 == 0)};
      n_vec++;
      if (got0 !== exp0) begin
        n_bad++;
        $display("FAIL no_repeat t=%0d got=%b exp=%b", t, got0, exp0);
      end
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL release_vs_repeat t=%0d got=%b exp=%b", t, got, exp);
      end
      btn = (t >= 10 && t <= 59) ? 1'b0 : 1'b1;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_short();
    test_long_repeat();
    test_bouncy_release();
    test_release_vs_long();
    test_reset_mid_hold();
    test_no_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage for the dual 7-segment timer. It replaces the bare monostable on each push-button.
- Synchronises and debounces one raw button, then emits single-cycle press and release events.
- Classifies each press as short or long, and generates auto-repeat pulses while the button stays held.
- Timer usage: short press means pause/resume; long press means reset to 59. One instance is used per button.

Parameters:
- ACTIVE_LOW, 1: raw button reads 0 when pressed; 0 means the raw button reads 1 when pressed.
- DEBOUNCE_CYC, 270000: consecutive stable cycles needed to accept a level change (10 ms at 27 MHz).
- LONG_CYC, 27000000: cycles from accepted press to the long-press event (1 s).
- REPEAT_CYC, 5400000: period of repeat pulses after a long press (200 ms); 0 disables repeat.

Ports:
- i_clk, input, 1: system clock, 27 MHz.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_btn, input, 1: raw button pin, asynchronous to i_clk.
- o_level, output, 1: debounced level, 1 = pressed.
- o_press, output, 1: one-cycle pulse when o_level goes 0->1.
- o_release, output, 1: one-cycle pulse when o_level goes 1->0.
- o_short, output, 1: one-cycle pulse on release when o_long never fired during that press.
- o_long, output, 1: one-cycle pulse exactly LONG_CYC cycles after o_press while the button is still held.
- o_repeat, output, 1: one-cycle pulse every REPEAT_CYC cycles after o_long while held.

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - Both sync flops are loaded with the released raw value (ACTIVE_LOW ? 1 : 0).
  - All counters are cleared, FSM goes to IDLE, and all outputs are 0.
- Sync stage:
  - Two-flop synchroniser, then polarity normalisation: p = sync2 ^ ACTIVE_LOW, where p=1 means pressed.
- Debounce:
  - Counter db_cnt, width clog2(DEBOUNCE_CYC)+1.
  - If p == o_level, db_cnt clears to 0.
  - Otherwise db_cnt increments. When db_cnt == DEBOUNCE_CYC-1 and p != o_level, o_level takes p and db_cnt clears.
  - Any single-cycle return of p to o_level restarts the count, so glitches shorter than DEBOUNCE_CYC cycles are ignored.
- Edge events:
  - o_press and o_release are registered and asserted in the same cycle o_level changes.
  - Latency from a clean raw edge to o_press is 2 + DEBOUNCE_CYC cycles.
- FSM states: IDLE, PRESSED, HELD.
  - IDLE -> PRESSED when o_press fires; hold_cnt clears.
  - PRESSED: hold_cnt increments each cycle. When it reaches LONG_CYC-1: o_long pulses for 1 cycle, go to HELD, hold_cnt clears.
  - PRESSED -> IDLE on o_release, with o_short pulsing in the same cycle as o_release.
  - HELD: if REPEAT_CYC>0, hold_cnt increments and wraps at REPEAT_CYC-1, pulsing o_repeat on each wrap. If REPEAT_CYC=0, o_repeat stays 0.
  - HELD -> IDLE on o_release; o_short stays 0.
- Simultaneity rules:
  - If the release occurs in the same cycle hold_cnt would hit its terminal value, release wins: no o_long and no o_repeat that cycle.
  - o_short wins over o_long in that cycle.
  - o_press and o_release are never asserted together.
- Counter widths: hold_cnt is sized for max(LONG_CYC, REPEAT_CYC). Counters saturate-free; they are always cleared on state change.
- Reset mid-operation:
  - All events are aborted.
  - If the button is still held after reset deasserts, it is treated as a fresh press: o_press follows after 2 + DEBOUNCE_CYC cycles.
- Outputs are glitch-free registers, suitable for direct edge use by the timer.

Test Plan:
All scenarios use ACTIVE_LOW=1, DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5; the cycle counter t starts at 0 when reset deasserts.
1. Glitch rejection: i_btn=0 for 3 cycles at t=10, then 1 -> o_level stays 0; no pulses on any output.
2. Short press: i_btn=0 from t=10 to t=24, then 1.
   - o_press and o_level rise at t=16.
   - o_release and o_short pulse together at t=31.
   - o_long and o_repeat stay 0.
3. Long hold with repeat: i_btn=0 from t=10 to t=60.
   - o_press at t=16, o_long at t=36, o_repeat at t=41, 46, 51, 56, 61, 66.
   - o_release at t=67; o_short stays 0.
4. Bouncy release: after o_press, drive i_btn 1,0,1,0 (single cycles), then steady 1.
   - Exactly one o_release, 4 cycles after the last bounce has passed the sync stage.
   - No second o_press.
5. Reset mid-hold: hold i_btn=0, then pulse i_rst_n low at t=40 (inside HELD).
   - All outputs go 0 immediately.
   - With i_btn still 0, o_press fires 6 cycles after i_rst_n returns high, and the FSM restarts from PRESSED.
6. REPEAT_CYC=0 variant: hold for 50 cycles -> o_long fires once and o_repeat never asserts.
